// File: rtl/rgb_lut_arbiter_if.sv
// Bundle of requester, colour-memory and pause handshake signals for rgb_lut_arbiter.
// master = arbiter side, slave = requesters / memory / pause controller side.
interface rgb_lut_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] colour_in;
    logic [N_REQ-1:0]   gnt;
    logic [2:0]         lut_colour;
    logic               lut_enable;
    logic [23:0]        lut_rgb;
    logic [23:0]        rgb_out;
    logic [ID_W-1:0]    rgb_id;
    logic               rgb_valid;
    logic               pause;
    logic               pause_ack;

    modport master (
        input  req, colour_in, lut_rgb, pause,
        output gnt, lut_colour, lut_enable, rgb_out, rgb_id, rgb_valid, pause_ack
    );

    modport slave (
        output req, colour_in, lut_rgb, pause,
        input  gnt, lut_colour, lut_enable, rgb_out, rgb_id, rgb_valid, pause_ack
    );
endinterface

// File: rtl/rgb_lut_arbiter.sv
// Round-robin arbiter sharing one registered RGB lookup memory, with pause/drain handshake.
// Optional grant statistics (gnt_count, last_gnt_id) enabled by defining RGB_ARB_STATS_EN.
module rgb_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    rgb_lut_arbiter_if.master bus
`ifdef RGB_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_count,
    output logic [ID_W-1:0]   last_gnt_id
`endif
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] req_rot;
    logic             found;
    logic [ID_W:0]    win_sum;
    logic [ID_W-1:0]  win_id;
    logic [2:0]       win_col;
    logic             grant_en;
    logic [N_REQ-1:0] gnt_d;
    logic             drain_done;

    logic             lut_enable_q;
    logic [2:0]       lut_colour_q;
    logic [ID_W-1:0]  tag1_id_q;
    logic             tag2_vld_q;
    logic [ID_W-1:0]  tag2_id_q;
    logic [23:0]      rgb_out_q;
    logic [ID_W-1:0]  rgb_id_q;
    logic             rgb_valid_q;
    logic             pause_ack_q;

    // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        req_rot = N_REQ'({bus.req, bus.req} >> ptr_q);
        found   = 1'b0;
        win_sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found   = 1'b1;
                win_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            end
        end
        if (win_sum >= (ID_W+1)'(N_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_REQ);
        end
        win_id = win_sum[ID_W-1:0];
    end

    assign grant_en = (state_q == S_RUN) && !bus.pause && !rst && found;

    always_comb begin
        gnt_d   = '0;
        win_col = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                gnt_d[i] = grant_en;
                win_col  = bus.colour_in[3*i +: 3];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en) begin
            ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end
    end

    // Stage-1 valid is lut_enable itself. Entering PAUSED once stage 1 and 2 are empty means
    // the output stage is empty by the time pause_ack rises.
    assign drain_done = !lut_enable_q && !tag2_vld_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (bus.pause) state_d = S_DRAIN;
            S_DRAIN:  if (!bus.pause) state_d = S_RUN;
                      else if (drain_done) state_d = S_PAUSED;
            S_PAUSED: if (!bus.pause) state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            ptr_q        <= '0;
            lut_enable_q <= 1'b0;
            lut_colour_q <= '0;
            tag1_id_q    <= '0;
            tag2_vld_q   <= 1'b0;
            tag2_id_q    <= '0;
            rgb_out_q    <= '0;
            rgb_id_q     <= '0;
            rgb_valid_q  <= 1'b0;
            pause_ack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lut_enable_q <= grant_en;
            if (grant_en) begin
                lut_colour_q <= win_col;
                tag1_id_q    <= win_id;
            end
            tag2_vld_q <= lut_enable_q;
            tag2_id_q  <= tag1_id_q;
            if (tag2_vld_q) begin
                rgb_out_q <= bus.lut_rgb;
                rgb_id_q  <= tag2_id_q;
            end
            rgb_valid_q <= tag2_vld_q;
            pause_ack_q <= (state_d == S_PAUSED);
        end
    end

    assign bus.gnt        = gnt_d;
    assign bus.lut_enable = lut_enable_q;
    assign bus.lut_colour = lut_colour_q;
    assign bus.rgb_out    = rgb_out_q;
    assign bus.rgb_id     = rgb_id_q;
    assign bus.rgb_valid  = rgb_valid_q;
    assign bus.pause_ack  = pause_ack_q;

`ifdef RGB_ARB_STATS_EN
    logic [15:0]     gnt_count_q;
    logic [ID_W-1:0] last_gnt_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_count_q   <= '0;
            last_gnt_id_q <= '0;
        end else if (grant_en) begin
            if (gnt_count_q != 16'hFFFF) gnt_count_q <= gnt_count_q + 16'd1;
            last_gnt_id_q <= win_id;
        end
    end

    assign gnt_count   = gnt_count_q;
    assign last_gnt_id = last_gnt_id_q;
`endif
endmodule
